reg_file_16: RTL and testbench

REG_FILE_16 -- requirements
Module: reg_file_16

---
 rtl/reg_file_16_pkg.sv | 15 +
 rtl/reg_file_16_read_port.sv | 36 +++
 rtl/reg_file_16.sv | 81 ++++++++
 tb/tb_reg_file_16.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_16_pkg
// Description : Shared CPU constants for the 16-bit register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_16_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_AW     = 3;
    localparam int c_NREGS  = 1 << c_AW;
    localparam int c_R0     = 0;

endpackage : reg_file_16_pkg
`default_nettype wire

// File: rtl/reg_file_16_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One register-file read port: array select, r0 zeroing and
//               write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
    import reg_file_16_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int NREGS  = c_NREGS,
    parameter int AW     = c_AW
) (
    input  logic [DATA_W-1:0] i_regs [NREGS],
    input  logic [AW-1:0]     i_ra,
    input  logic              i_byp_en,
    input  logic [AW-1:0]     i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd
);

    localparam logic [AW-1:0] c_RZ = AW'(c_R0);

    // r0 wins over the bypass; i_byp_en already excludes wa==0
    always_comb begin
        o_rd = i_regs[i_ra];
        if (i_ra == c_RZ) begin
            o_rd = '0;
        end else if (i_byp_en && (i_ra == i_wa)) begin
            o_rd = i_wd;
        end
    end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_16.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_16
// Description : 8 x 16-bit register file, r0 hardwired to zero, two bypassed
//               read ports, a raw debug port and a committed-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_16
    import reg_file_16_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int NREGS  = c_NREGS,
    parameter int AW     = c_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              stall,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [15:0]       wr_cnt
);

    localparam logic [AW-1:0] c_RZ = AW'(c_R0);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [15:0]       r_wr_cnt;
    logic              w_commit;

    // Single qualifier shared by the array write, the counter and both bypasses
    assign w_commit = rst_n && we && !stall && (wa != c_RZ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_regs[wa] <= wd;
            r_wr_cnt   <= r_wr_cnt + 16'd1;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_rd1 (
        .i_regs   (r_regs),
        .i_ra     (ra1),
        .i_byp_en (w_commit),
        .i_wa     (wa),
        .i_wd     (wd),
        .o_rd     (rd1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_rd2 (
        .i_regs   (r_regs),
        .i_ra     (ra2),
        .i_byp_en (w_commit),
        .i_wa     (wa),
        .i_wd     (wd),
        .o_rd     (rd2)
    );

    assign dbg_d  = (dbg_a == c_RZ) ? '0 : r_regs[dbg_a];
    assign wr_cnt = r_wr_cnt;

endmodule : reg_file_16
`default_nettype wire

// File: tb/tb_reg_file_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_16
// Description : Scoreboard bench for reg_file_16 against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_16;

    logic        clk = 1'b0;
    logic        rst_n, we, stall;
    logic [2:0]  wa, ra1, ra2, dbg_a;
    logic [15:0] wd;
    logic [15:0] rd1, rd2, dbg_d, wr_cnt;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] dbg;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q_exp [$];
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .stall  (stall),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .rd1    (rd1),
        .ra2    (ra2),
        .rd2    (rd2),
        .dbg_a  (dbg_a),
        .dbg_d  (dbg_d),
        .wr_cnt (wr_cnt)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle's response is valid at negedge
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            check("rd1", rd1, e.rd1);
            check("rd2", rd2, e.rd2);
            check("dbg_d", dbg_d, e.dbg);
            check("wr_cnt", wr_cnt, e.cnt);
        end
    end

    function automatic logic [15:0] model_read(input logic [2:0] ra, input logic byp);
        if (ra == 3'd0) return 16'h0000;
        if (byp && ra == wa) return wd;
        return m_regs[ra];
    endfunction

    // Drive one cycle, push its expected response, then advance the model on the edge
    task automatic cycle(input logic r, input logic w, input logic s, input logic [2:0] a,
                         input logic [15:0] d, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] ad, input logic chk);
        logic wr_ok;
        exp_t e;
        rst_n = r; we = w; stall = s; wa = a; wd = d;
        ra1 = a1; ra2 = a2; dbg_a = ad;
        wr_ok = r && w && !s && (a != 3'd0);
        e.rd1 = model_read(a1, wr_ok);
        e.rd2 = model_read(a2, wr_ok);
        e.dbg = (ad == 3'd0) ? 16'h0000 : m_regs[ad];
        e.cnt = m_cnt;
        if (chk) q_exp.push_back(e);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_cnt = 16'h0000;
        end else if (wr_ok) begin
            m_regs[a] = d;
            m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_cnt = 16'h0000;
        @(posedge clk);
        #1;
        // Two unchecked reset edges establish known state
        cycle(1'b0, 1'b1, 1'b0, 3'd3, 16'hDEAD, 3'd0, 3'd0, 3'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b0);
        // Reset-time reads and read-all after reset
        cycle(1'b0, 1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd3, 3'd3, 3'd3, 1'b1);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 3'(i), 1'b1);

        // Directed write, bypass, r0, stall scenarios
        cycle(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 3'd0, 3'd1, 3'd3, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 3'd3, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd5, 16'h00AA, 3'd5, 3'd5, 3'd5, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 3'd5, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd2, 16'h0011, 3'd2, 3'd1, 3'd2, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'd2, 16'h0BAD, 3'd2, 3'd2, 3'd2, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 3'd2, 1'b1);
        // Back-to-back rewrites of one register
        cycle(1'b1, 1'b1, 1'b0, 3'd6, 16'h1111, 3'd6, 3'd6, 3'd6, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd6, 16'h2222, 3'd6, 3'd6, 3'd6, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 3'd6, 1'b1);

        // Randomised traffic including occasional mid-sequence resets
        for (int n = 0; n < 600; n++) begin
            logic       r, w, s;
            logic [2:0] a, a1, a2, ad;
            r  = ($urandom_range(0, 31) != 0);
            w  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
            ad = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
            cycle(r, w, s, a, 16'($urandom), a1, a2, ad, 1'b1);
        end

        // Drive the counter up to 16'hFFFF; the final preload lands in reg[4]
        while (m_cnt != 16'hFFFF) begin
            logic [2:0] a;
            a = (m_cnt == 16'hFFFE) ? 3'd4 : 3'(1 + ($urandom_range(0, 6)));
            cycle(1'b1, 1'b1, 1'b0, a, 16'($urandom) | 16'h0001, 3'd4, a, 3'd4, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd1, 3'd4, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd7, 16'h7777, 3'd7, 3'd4, 3'd7, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd4, 3'd4, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 3'd4, 16'hABCD, 3'd4, 3'd4, 3'd4, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd7, 3'd4, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'd1, 16'h00C3, 3'd1, 3'd1, 3'd1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd4, 3'd1, 1'b1);

        for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(posedge clk);
        if (q_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses left, expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_file_16
`default_nettype wire
